dcache_wb: RTL and testbench
============================

Name: dcache_wb

Overview:
- Parametrised successor to the single-word direct-mapped cache.
- Direct-mapped, write-back, write-allocate data cache with multi-word lines and per-line dirty bits.
- A miss-handling FSM talks to a line-wide valid/ready memory port.
- Sits between the MEM pipeline stage and the memory arbiter. Stalls the core via cpu_req_ready during misses.

Parameters:
- NUM_LINES, 4, number of lines; power of 2, ≥2.
- WORDS_PER_LINE, 4, words per line; power of 2, ≥1.
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, XLEN, word width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req_valid  in  1  core request present
- cpu_req_write  in  1  1=store, 0=load
- cpu_req_addr  in  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored
- cpu_req_wdata  in  DATA_WIDTH  store data
- cpu_req_ready  out  1  cache can accept a request
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_rdata  out  DATA_WIDTH  load data, valid with cpu_resp_valid
- hit  out  1  pulse with cpu_resp_valid when the request hit without a refill
- mem_req_valid  out  1  memory request
- mem_req_write  out  1  1=writeback, 0=refill
- mem_req_addr  out  ADDR_WIDTH  line-aligned byte address
- mem_req_wdata  out  WORDS_PER_LINE*DATA_WIDTH  victim line; word 0 in the LSBs
- mem_req_ready  in  1  memory accepts the request
- mem_resp_valid  in  1  refill data present
- mem_resp_rdata  in  WORDS_PER_LINE*DATA_WIDTH  refill line

Behaviour:
- Address split, LSB→MSB:
  - byte offset, BO=$clog2(DATA_WIDTH/8)
  - word offset, WO=$clog2(WORDS_PER_LINE)
  - index, IX=$clog2(NUM_LINES)
  - tag, ADDR_WIDTH-BO-WO-IX bits
- Reset:
  - state=IDLE; all valid and dirty bits cleared.
  - cpu_resp_valid=0, hit=0, mem_req_valid=0, mem_req_write=0, cpu_resp_rdata=0.
  - Tag and data arrays are not reset.
- States: IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND.
- IDLE:
  - cpu_req_ready=1; the request is accepted when cpu_req_valid=1.
  - On accept, the request is latched and lookup uses the latched index/tag against the arrays.
  - Hit means valid[idx] && tag[idx]==req_tag.
- Hit path (latency 1):
  - Next cycle: cpu_resp_valid=1 and hit=1.
  - Load: rdata = word[woff].
  - Store: word[woff] updated, dirty[idx]=1, rdata=0.
  - State stays IDLE, so back-to-back hits give one response per cycle.
- Miss path:
  - Victim valid && dirty → WRITEBACK; otherwise → REFILL_REQ.
  - cpu_req_ready=0 from the cycle after accept until return to IDLE.
- WRITEBACK:
  - mem_req_valid=1, mem_req_write=1, addr={victim_tag, idx, 0}, wdata=victim line.
  - All held stable until mem_req_ready=1; then → REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid=1, mem_req_write=0, addr={req_tag, idx, 0}, held stable.
  - On mem_req_ready → REFILL_WAIT.
- REFILL_WAIT:
  - On mem_resp_valid: install line, tag=req_tag, valid=1, dirty=0 → RESPOND.
- RESPOND (one cycle):
  - Performs the latched op on the installed line (store merges word and sets dirty=1).
  - cpu_resp_valid=1, hit=0 → IDLE.
- mem_req_valid is never asserted outside WRITEBACK and REFILL_REQ.
- mem_resp_valid outside REFILL_WAIT is ignored and changes no state.
- Responses have no backpressure; the consumer must accept a pulse in the cycle it is issued.
- rst in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - The pending request is dropped with no response.
  - An outstanding memory transaction is abandoned; the memory side is reset together with the cache.
- Unknown-free: cpu_resp_rdata=0 whenever cpu_resp_valid=0.

Decomposition:
- brisc_pkg gains:
  - dcache_state_e enum (IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESPOND)
  - DCACHE_LINES and DCACHE_WORDS defaults
- Sub-module dcache_array:
  - Tag/data/valid/dirty storage.
  - One combinational read port by index.
  - Write ports: full-line install, single-word write, and clear-all.
  - Keeps the FSM file separate from the storage.

Test Plan (NUM_LINES=4, WORDS_PER_LINE=4, 32-bit):
1. Cold read miss. After rst, load 0x0000_0040.
   - mem_req addr=0x40, write=0.
   - Reply with line {0x13,0x12,0x11,0x10} (word 0 = 0x10).
   - Expect RESPOND: rdata=0x10, hit=0.
2. Load hit. Load 0x0000_0044 next.
   - One cycle later: cpu_resp_valid=1, hit=1, rdata=0x11, and no mem_req.
3. Dirty eviction.
   - Store 0xDEADBEEF to 0x48 (hit, dirty), then load 0x148.
   - Expect a writeback at addr 0x40 with word 2=0xDEADBEEF, then a refill read at 0x140.
4. Backpressure. Hold mem_req_ready=0 for 5 cycles during REFILL_REQ.
   - mem_req_valid, addr and write are stable throughout.
   - cpu_req_ready=0 throughout.
5. Reset mid-operation. Assert rst in REFILL_WAIT.
   - Next cycle: mem_req_valid=0 and no cpu_resp_valid.
   - Re-load 0x40 misses again.
6. Stray response. Pulse mem_resp_valid in IDLE with arbitrary data.
   - No state change; a subsequent load to 0x44 still returns the originally cached 0x11.

Source files
------------

// File: rtl/brisc_pkg.sv
// brisc_pkg: shared core-wide types and defaults.
//   XLEN            - architectural word width
//   DCACHE_LINES    - default data-cache line count
//   DCACHE_WORDS    - default words per data-cache line
//   dcache_state_e  - data-cache miss-handling FSM states
package brisc_pkg;

    localparam int XLEN         = 32;
    localparam int DCACHE_LINES = 4;
    localparam int DCACHE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WAIT,
        RESPOND
    } dcache_state_e;

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag/data/valid/dirty storage for the direct-mapped data cache.
// All ports share one line index (the cache only ever touches the line of the
// request in flight).
//   clk, rst         - clock, synchronous active-high reset (clears valid/dirty only)
//   idx              - line index for every port
//   rd_valid/dirty/tag/line - combinational read of line idx
//   inst_en/tag/line - full-line install: valid=1, dirty=0
//   wr_en/woff/data  - single-word write: dirty=1
module dcache_array #(
    parameter int NUM_LINES      = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_W          = 26,
    parameter int IX_W           = 2,
    parameter int WO_W           = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [IX_W-1:0]                          idx,
    output logic                                     rd_valid,
    output logic                                     rd_dirty,
    output logic [TAG_W-1:0]                         rd_tag,
    output logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] rd_line,
    input  logic                                     inst_en,
    input  logic [TAG_W-1:0]                         inst_tag,
    input  logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] inst_line,
    input  logic                                     wr_en,
    input  logic [WO_W-1:0]                          wr_woff,
    input  logic [DATA_WIDTH-1:0]                    wr_data
);

    logic [NUM_LINES-1:0]                                valid_q, valid_d;
    logic [NUM_LINES-1:0]                                dirty_q, dirty_d;
    logic [NUM_LINES-1:0][TAG_W-1:0]                     tag_q, tag_d;
    logic [NUM_LINES-1:0][WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] data_q, data_d;

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (inst_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
            tag_d[idx]   = inst_tag;
            data_d[idx]  = inst_line;
        end
        if (wr_en) begin
            data_d[idx][wr_woff] = wr_data;
            dirty_d[idx]         = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and data are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache with
// multi-word lines and a line-wide valid/ready memory port.
//   clk, rst                     - clock, synchronous active-high reset
//   cpu_req_*                    - core request (valid/ready handshake)
//   cpu_resp_valid/rdata, hit    - one-cycle completion pulse, no backpressure
//   mem_req_*                    - line writeback (write=1) or refill (write=0)
//   mem_resp_valid/rdata         - refill data, only consumed in REFILL_WAIT
module dcache_wb
    import brisc_pkg::*;
#(
    parameter int NUM_LINES      = DCACHE_LINES,
    parameter int WORDS_PER_LINE = DCACHE_WORDS,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = XLEN
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cpu_req_valid,
    input  logic                                 cpu_req_write,
    input  logic [ADDR_WIDTH-1:0]                cpu_req_addr,
    input  logic [DATA_WIDTH-1:0]                cpu_req_wdata,
    output logic                                 cpu_req_ready,
    output logic                                 cpu_resp_valid,
    output logic [DATA_WIDTH-1:0]                cpu_resp_rdata,
    output logic                                 hit,
    output logic                                 mem_req_valid,
    output logic                                 mem_req_write,
    output logic [ADDR_WIDTH-1:0]                mem_req_addr,
    output logic [WORDS_PER_LINE*DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                                 mem_req_ready,
    input  logic                                 mem_resp_valid,
    input  logic [WORDS_PER_LINE*DATA_WIDTH-1:0] mem_resp_rdata
);

    localparam int BO    = $clog2(DATA_WIDTH / 8);
    localparam int WO    = $clog2(WORDS_PER_LINE);
    localparam int IX    = $clog2(NUM_LINES);
    localparam int WO_W  = (WO > 0) ? WO : 1;
    localparam int TAG_W = ADDR_WIDTH - BO - WO - IX;

    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                        input logic [IX-1:0]    i);
        return (ADDR_WIDTH'(t) << (BO + WO + IX)) | (ADDR_WIDTH'(i) << (BO + WO));
    endfunction

    dcache_state_e           state_q, state_d;
    // pend_q: a request was accepted last cycle and is being looked up now.
    logic                    pend_q, pend_d;
    logic                    req_write_q, req_write_d;
    logic [IX-1:0]           req_idx_q, req_idx_d;
    logic [TAG_W-1:0]        req_tag_q, req_tag_d;
    logic [WO_W-1:0]         req_woff_q, req_woff_d;
    logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;

    logic                    rd_valid, rd_dirty, lookup_hit;
    logic [TAG_W-1:0]        rd_tag;
    logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] rd_line;
    logic                    inst_en, wr_en, accept;

    dcache_array #(
        .NUM_LINES(NUM_LINES), .WORDS_PER_LINE(WORDS_PER_LINE),
        .DATA_WIDTH(DATA_WIDTH), .TAG_W(TAG_W), .IX_W(IX), .WO_W(WO_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx      (req_idx_q),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .inst_en  (inst_en),
        .inst_tag (req_tag_q),
        .inst_line(mem_resp_rdata),
        .wr_en    (wr_en),
        .wr_woff  (req_woff_q),
        .wr_data  (req_wdata_q)
    );

    assign lookup_hit = rd_valid && (rd_tag == req_tag_q);

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        req_write_d    = req_write_q;
        req_idx_d      = req_idx_q;
        req_tag_d      = req_tag_q;
        req_woff_d     = req_woff_q;
        req_wdata_d    = req_wdata_q;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        hit            = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_write  = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        inst_en        = 1'b0;
        wr_en          = 1'b0;
        accept         = 1'b0;

        case (state_q)
            IDLE: begin
                // A hit frees the cache in the same cycle, so hits stream at one per cycle.
                cpu_req_ready = !pend_q || lookup_hit;
                if (pend_q) begin
                    if (lookup_hit) begin
                        cpu_resp_valid = 1'b1;
                        hit            = 1'b1;
                        if (req_write_q) wr_en = 1'b1;
                        else             cpu_resp_rdata = rd_line[req_woff_q];
                    end else begin
                        state_d = (rd_valid && rd_dirty) ? WRITEBACK : REFILL_REQ;
                    end
                end
                accept = cpu_req_ready && cpu_req_valid;
                pend_d = accept;
                if (accept) begin
                    req_write_d = cpu_req_write;
                    req_idx_d   = IX'(cpu_req_addr >> (BO + WO));
                    req_tag_d   = TAG_W'(cpu_req_addr >> (BO + WO + IX));
                    req_woff_d  = (WO == 0) ? '0 : WO_W'(cpu_req_addr >> BO);
                    req_wdata_d = cpu_req_wdata;
                end
            end
            WRITEBACK: begin
                // Victim line stays in the array until install, so these are stable.
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = line_addr(rd_tag, req_idx_q);
                mem_req_wdata = rd_line;
                if (mem_req_ready) state_d = REFILL_REQ;
            end
            REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = line_addr(req_tag_q, req_idx_q);
                if (mem_req_ready) state_d = REFILL_WAIT;
            end
            REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    inst_en = 1'b1;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                cpu_resp_valid = 1'b1;
                if (req_write_q) wr_en = 1'b1;
                else             cpu_resp_rdata = rd_line[req_woff_q];
                state_d = IDLE;
                pend_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        req_write_q <= req_write_d;
        req_idx_q   <= req_idx_d;
        req_tag_q   <= req_tag_d;
        req_woff_q  <= req_woff_d;
        req_wdata_q <= req_wdata_d;
    end

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed stimulus with a response scoreboard for dcache_wb
// (4 lines x 4 words x 32 bits).
module tb_dcache_wb;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req_valid, cpu_req_write;
    logic [31:0]  cpu_req_addr, cpu_req_wdata;
    logic         cpu_req_ready, cpu_resp_valid, hit;
    logic [31:0]  cpu_resp_rdata;
    logic         mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata, mem_resp_rdata;

    dcache_wb #(.NUM_LINES(4), .WORDS_PER_LINE(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata), .hit(hit),
        .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        hit;
    } resp_t;

    resp_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    localparam logic [127:0] L40  = {32'h13, 32'h12, 32'h11, 32'h10};
    localparam logic [127:0] L140 = {32'h23, 32'h22, 32'h21, 32'h20};
    localparam logic [127:0] L50  = {32'h33, 32'h32, 32'h31, 32'h30};
    localparam logic [127:0] WB40 = {32'h13, 32'hDEADBEEF, 32'h11, 32'h10};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        resp_t e;
        if (!rst && cpu_resp_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata=%0h hit=%0b, required no response",
                         cpu_resp_rdata, hit);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", cpu_resp_rdata, e.rdata);
                check("resp_hit", hit, e.hit);
            end
        end
    end

    task automatic cpu_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cpu_req_valid = 1'b1;
        cpu_req_write = wr;
        cpu_req_addr  = a;
        cpu_req_wdata = d;
        @(negedge clk);
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) check("req_accept_timeout", cpu_req_ready, 1'b1);
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
    endtask

    // Wait for a memory request, check it, optionally hold ready low for
    // `delay` cycles, accept it, and optionally return a refill line.
    task automatic mem_expect(input logic wr, input logic [31:0] a, input logic [127:0] wd,
                              input int delay, input logic give_resp, input logic [127:0] line);
        int n = 0;
        @(negedge clk);
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_valid", mem_req_valid, 1'b1);
        check("mem_req_write", mem_req_write, wr);
        check("mem_req_addr", mem_req_addr, a);
        if (wr) check("mem_req_wdata", mem_req_wdata, wd);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("bp_valid", mem_req_valid, 1'b1);
            check("bp_write", mem_req_write, wr);
            check("bp_addr", mem_req_addr, a);
            check("bp_cpu_ready", cpu_req_ready, 1'b0);
        end
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        if (give_resp) begin
            @(negedge clk);
            mem_resp_valid = 1'b1;
            mem_resp_rdata = line;
            @(posedge clk);
            #1 mem_resp_valid = 1'b0;
            mem_resp_rdata = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cpu_req_valid = 1'b0; cpu_req_write = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cpu_ready", cpu_req_ready, 1'b1);
        check("rst_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_rdata", cpu_resp_rdata, 32'h0);
        check("rst_mem_valid", mem_req_valid, 1'b0);
        check("rst_mem_write", mem_req_write, 1'b0);
        @(posedge clk); #1;

        // Cold read miss.
        exp_q.push_back('{rdata: 32'h10, hit: 1'b0});
        cpu_req(1'b0, 32'h40, 32'h0);
        mem_expect(1'b0, 32'h40, '0, 0, 1'b1, L40);
        drain();

        // Load hit, one-cycle latency, no memory traffic.
        exp_q.push_back('{rdata: 32'h11, hit: 1'b1});
        cpu_req(1'b0, 32'h44, 32'h0);
        @(negedge clk);
        check("hit_latency", cpu_resp_valid, 1'b1);
        check("hit_no_memreq", mem_req_valid, 1'b0);
        drain();

        // Store hit dirties line 0, then a conflicting load forces writeback;
        // the refill is held off for 5 cycles.
        exp_q.push_back('{rdata: 32'h0, hit: 1'b1});
        cpu_req(1'b1, 32'h48, 32'hDEADBEEF);
        drain();
        exp_q.push_back('{rdata: 32'h22, hit: 1'b0});
        cpu_req(1'b0, 32'h148, 32'h0);
        mem_expect(1'b1, 32'h40, WB40, 0, 1'b0, '0);
        mem_expect(1'b0, 32'h140, '0, 5, 1'b1, L140);
        drain();

        // Store miss allocates, then the merged word reads back as a hit.
        exp_q.push_back('{rdata: 32'h0, hit: 1'b0});
        cpu_req(1'b1, 32'h54, 32'h5A5A5A5A);
        mem_expect(1'b0, 32'h50, '0, 0, 1'b1, L50);
        drain();
        exp_q.push_back('{rdata: 32'h5A5A5A5A, hit: 1'b1});
        cpu_req(1'b0, 32'h54, 32'h0);
        drain();

        // Reset while waiting for refill data: request dropped, then misses again.
        cpu_req(1'b0, 32'h40, 32'h0);
        mem_expect(1'b0, 32'h40, '0, 0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_valid", mem_req_valid, 1'b0);
        check("rst_mid_resp_valid", cpu_resp_valid, 1'b0);
        check("rst_mid_cpu_ready", cpu_req_ready, 1'b1);
        @(posedge clk); #1;
        exp_q.push_back('{rdata: 32'h10, hit: 1'b0});
        cpu_req(1'b0, 32'h40, 32'h0);
        mem_expect(1'b0, 32'h40, '0, 0, 1'b1, L40);
        drain();

        // Stray memory response in IDLE must change nothing.
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {4{32'hBADBAD00}};
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        @(negedge clk);
        check("stray_resp_valid", cpu_resp_valid, 1'b0);
        check("stray_mem_valid", mem_req_valid, 1'b0);
        @(posedge clk); #1;
        exp_q.push_back('{rdata: 32'h11, hit: 1'b1});
        cpu_req(1'b0, 32'h44, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
